// File: rtl/dp_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dp_sequencer_pkg
//  Purpose  : Shared definitions for the datapath sequencer: instruction width,
//             packed micro-instruction layout and FSM state encodings.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package dp_sequencer_pkg;

  localparam int INSTR_W = 12;

  // Fields that are driven onto the datapath while an instruction executes.
  typedef struct packed {
    logic [2:0] alu;    // [11:9]
    logic [1:0] addr1;  // [8:7]
    logic [1:0] addr2;  // [6:5]
    logic [1:0] addr3;  // [4:3]
    logic       wr;     // [2]
  } issue_t;

  // Full micro-instruction: issue fields plus repeat count (issued rpt+1 times).
  typedef struct packed {
    issue_t     op;
    logic [1:0] rpt;    // [1:0]
  } instr_t;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_EXEC = 1'b1;

endpackage
`default_nettype wire

// File: rtl/dp_sequencer_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : dp_seq_fifo
//  Purpose  : Instruction buffer, DEPTH x WIDTH, single clock. Push is refused
//             whenever full (even with a pop in the same cycle); pop is ignored
//             when empty. head_o is the oldest entry.
//  Ports    : clk, rst (async, active-high)
//             push_i, data_i  -> write side
//             pop_i           -> read side, advances head
//             full_o, empty_o, head_o
//  Revision : 1.0  initial release
// ============================================================================
module dp_seq_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int           AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]  C_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      cnt_q;
  logic             w_push, w_pop;

  assign full_o  = (cnt_q == C_FULL);
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rptr_q];

  // Gating on the registered flags makes "push while full" a refusal even if
  // the same cycle frees a slot.
  assign w_push = push_i & ~full_o;
  assign w_pop  = pop_i  & ~empty_o;

  // Storage carries no reset: contents are only observed when count says valid.
  always_ff @(posedge clk) begin
    if (w_push) mem_q[wptr_q] <= data_i;
  end

  // DEPTH is a power of two, so natural pointer overflow is the modulo wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (w_push) wptr_q <= wptr_q + AW'(1);
      if (w_pop)  rptr_q <= rptr_q + AW'(1);
      case ({w_push, w_pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/dp_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : dp_sequencer
//  Purpose  : Control stage for the 4x32 register-file/ALU datapath. Buffers
//             12-bit micro-instructions, issues them one per cycle with 1..4
//             repeats, keeps a sticky carry flag and an issue-cycle counter.
//  Ports    : clk, rst (async, active-high)
//             in_instr/in_valid/in_ready  instruction handshake
//             halt       stall issue (buffer still fills)
//             cout       datapath carry-out
//             clr_flags  sync clear of carry_flag and op_count
//             addr1/addr2/addr3/alu/wr   datapath control
//             busy, carry_flag, op_count status
//  Revision : 1.0  initial release
// ============================================================================
module dp_sequencer
  import dp_sequencer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               halt,
  input  logic               cout,
  input  logic               clr_flags,
  output logic [1:0]         addr1,
  output logic [1:0]         addr2,
  output logic [1:0]         addr3,
  output logic [2:0]         alu,
  output logic               wr,
  output logic               busy,
  output logic               carry_flag,
  output logic [CNT_W-1:0]   op_count
);

  logic [0:0]         state_q, state_d;
  issue_t             instr_q, instr_d;
  logic [1:0]         rep_q, rep_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               w_full, w_empty, w_pop, w_push, w_issue;
  logic [INSTR_W-1:0] w_head_raw;
  instr_t             w_head;

  assign w_push   = in_valid & ~w_full;
  assign in_ready = ~w_full;
  assign w_head   = instr_t'(w_head_raw);

  dp_seq_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (INSTR_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (w_push),
    .data_i  (in_instr),
    .pop_i   (w_pop),
    .full_o  (w_full),
    .empty_o (w_empty),
    .head_o  (w_head_raw)
  );

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    rep_d   = rep_q;
    w_pop   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!halt && !w_empty) begin
          w_pop   = 1'b1;
          instr_d = w_head.op;
          rep_d   = w_head.rpt;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (!halt) begin
          if (rep_q != 2'd0) begin
            rep_d = rep_q - 2'd1;
          end else if (!w_empty) begin
            // Load the next instruction on the last repeat: no idle bubble.
            w_pop   = 1'b1;
            instr_d = w_head.op;
            rep_d   = w_head.rpt;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign w_issue = (state_q == ST_EXEC) & ~halt;

  // Address/opcode fields simply mirror the instruction register, so they
  // hold their last values in IDLE; only wr is qualified.
  assign addr1 = instr_q.addr1;
  assign addr2 = instr_q.addr2;
  assign addr3 = instr_q.addr3;
  assign alu   = instr_q.alu;
  assign wr    = w_issue & instr_q.wr;

  assign busy       = (state_q != ST_IDLE) | ~w_empty;
  assign carry_flag = carry_q;
  assign op_count   = cnt_q;

  always_comb begin
    carry_d = carry_q;
    cnt_d   = cnt_q;
    if (clr_flags) begin
      carry_d = 1'b0;
      cnt_d   = '0;
    end else begin
      if (wr && cout) carry_d = 1'b1;
      if (w_issue)    cnt_d   = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      instr_q <= '0;
      rep_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      rep_q   <= rep_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dp_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dp_sequencer
//  Purpose  : Self-checking bench for dp_sequencer. Issued instructions with
//             wr=1 are queued as expected datapath fields; a negedge monitor
//             pops and compares every cycle the DUT drives wr=1.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dp_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] in_instr;
  logic        in_valid, in_ready, halt, cout, clr_flags;
  logic [1:0]  addr1, addr2, addr3;
  logic [2:0]  alu;
  logic        wr, busy, carry_flag;
  logic [15:0] op_count;

  int n_tests = 0;
  int n_fail  = 0;
  int wr_cycles = 0;
  int run_len = 0;
  int max_run = 0;
  logic [8:0] exp_q [$];

  dp_sequencer #(.DEPTH(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_instr(in_instr), .in_valid(in_valid),
    .in_ready(in_ready), .halt(halt), .cout(cout), .clr_flags(clr_flags),
    .addr1(addr1), .addr2(addr2), .addr3(addr3), .alu(alu), .wr(wr),
    .busy(busy), .carry_flag(carry_flag), .op_count(op_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every wr=1 cycle must match the oldest expected issue.
  always @(negedge clk) begin
    if (wr === 1'b1) begin
      wr_cycles++;
      run_len++;
      if (run_len > max_run) max_run = run_len;
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL issue_unexpected: got %0h expected none", {alu, addr1, addr2, addr3});
      end else begin
        check("issue_fields", {23'd0, alu, addr1, addr2, addr3}, {23'd0, exp_q.pop_front()});
      end
    end else begin
      run_len = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_instr(input logic [11:0] ins);
    int  k;
    logic acc;
    logic [1:0] rpt;
    in_instr = ins;
    in_valid = 1'b1;
    k = 0;
    acc = 1'b0;
    while (!acc && k < 50) begin
      acc = in_ready;
      tick();
      k++;
    end
    in_valid = 1'b0;
    if (!acc) begin
      check("push_timeout", 32'd0, 32'd1);
    end else if (ins[2]) begin
      rpt = ins[1:0];
      for (int r = 0; r <= int'(rpt); r++)
        exp_q.push_back({ins[11:9], ins[8:7], ins[6:5], ins[4:3]});
    end
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 60) begin
      tick();
      k++;
    end
    if (busy) check("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_wr();
    int k = 0;
    while (!wr && k < 60) begin
      tick();
      k++;
    end
    if (!wr) check("wr_timeout", 32'd0, 32'd1);
  endtask

  task automatic clear_flags();
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
  endtask

  int base;

  initial begin
    rst = 1'b1; in_instr = '0; in_valid = 1'b0; halt = 1'b0;
    cout = 1'b0; clr_flags = 1'b0;
    #3;
    check("rst_wr", {31'd0, wr}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_op_count", {16'd0, op_count}, 32'd0);
    check("rst_carry", {31'd0, carry_flag}, 32'd0);
    check("rst_fields", {23'd0, alu, addr1, addr2, addr3}, 32'd0);
    #19 rst = 1'b0;
    tick();

    // Single instruction: one issue cycle, then IDLE with fields held.
    base = wr_cycles; max_run = 0;
    push_instr(12'b000_01_10_11_1_00);
    wait_idle();
    check("single_wr_cycles", wr_cycles - base, 32'd1);
    check("single_op_count", {16'd0, op_count}, 32'd1);
    check("single_idle_wr", {31'd0, wr}, 32'd0);
    check("single_hold_fields", {23'd0, alu, addr1, addr2, addr3}, {23'd0, 9'b000_01_10_11});

    // rpt=3: four consecutive write cycles.
    clear_flags();
    check("clr_op_count", {16'd0, op_count}, 32'd0);
    base = wr_cycles; max_run = 0;
    push_instr(12'b101_10_11_00_1_11);
    wait_idle();
    check("rpt_wr_cycles", wr_cycles - base, 32'd4);
    check("rpt_max_run", max_run, 32'd4);
    check("rpt_op_count", {16'd0, op_count}, 32'd4);

    // Fill under halt, 5th refused, then back-to-back drain in order.
    halt = 1'b1;
    base = wr_cycles; max_run = 0;
    push_instr(12'b001_00_01_10_1_00);
    push_instr(12'b010_01_10_11_1_00);
    push_instr(12'b011_10_11_00_1_00);
    push_instr(12'b100_11_00_01_1_00);
    check("full_in_ready", {31'd0, in_ready}, 32'd0);
    check("full_busy", {31'd0, busy}, 32'd1);
    in_instr = 12'b111_11_11_11_1_00;
    in_valid = 1'b1;
    repeat (3) tick();
    check("full_refuse", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b0;
    check("halt_no_issue", wr_cycles - base, 32'd0);
    halt = 1'b0;
    wait_idle();
    check("drain_wr_cycles", wr_cycles - base, 32'd4);
    check("drain_no_bubble", max_run, 32'd4);
    check("drain_queue_empty", exp_q.size(), 32'd0);

    // Halt for two cycles in the middle of a 4-repeat instruction.
    clear_flags();
    base = wr_cycles;
    push_instr(12'b110_00_11_01_1_11);
    wait_wr();
    tick();
    halt = 1'b1;
    #1 check("halt_wr_low", {31'd0, wr}, 32'd0);
    tick();
    check("halt_wr_low2", {31'd0, wr}, 32'd0);
    tick();
    halt = 1'b0;
    wait_idle();
    check("halt_total_issues", wr_cycles - base, 32'd4);
    check("halt_op_count", {16'd0, op_count}, 32'd4);

    // Sticky carry, wr=0 never sets it, clr beats same-cycle set.
    clear_flags();
    cout = 1'b1;
    push_instr(12'b000_00_00_00_0_00);
    wait_idle();
    check("carry_no_wr", {31'd0, carry_flag}, 32'd0);
    push_instr(12'b001_01_01_01_1_00);
    wait_idle();
    check("carry_set", {31'd0, carry_flag}, 32'd1);
    cout = 1'b0;
    repeat (3) tick();
    check("carry_sticky", {31'd0, carry_flag}, 32'd1);
    clear_flags();
    check("carry_clr", {31'd0, carry_flag}, 32'd0);
    cout = 1'b1;
    push_instr(12'b010_10_10_10_1_00);
    wait_wr();
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    check("carry_clr_priority", {31'd0, carry_flag}, 32'd0);
    wait_idle();

    // Asynchronous reset in the middle of a repeat with more work buffered.
    clear_flags();
    push_instr(12'b110_01_01_01_1_11);
    push_instr(12'b011_11_10_01_1_00);
    wait_wr();
    tick();
    check("pre_rst_carry", {31'd0, carry_flag}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_wr", {31'd0, wr}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("mid_rst_op_count", {16'd0, op_count}, 32'd0);
    check("mid_rst_carry", {31'd0, carry_flag}, 32'd0);
    exp_q.delete();
    cout = 1'b0;
    #13 rst = 1'b0;
    base = wr_cycles;
    repeat (6) tick();
    check("post_rst_no_issue", wr_cycles - base, 32'd0);
    check("post_rst_busy", {31'd0, busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
